// File: rtl/device_pkg.sv
// Shared constants for uCISC bus devices: slot numbers, block offsets and register layouts.
package device_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 8;

   localparam logic [7:0] SLOT_TIMER = 8'h03;

   localparam logic [DATA_W-1:0] TIMER_DEVICE_ID   = 16'h0300;
   localparam logic [DATA_W-1:0] TIMER_DEVICE_TYPE = 16'h0004;

   // Control-block word offsets common to every device
   localparam logic [ADDR_W-1:0] CTL_ID     = 8'd0;
   localparam logic [ADDR_W-1:0] CTL_TYPE   = 8'd1;
   localparam logic [ADDR_W-1:0] CTL_CTRL   = 8'd2;
   localparam logic [ADDR_W-1:0] CTL_STATUS = 8'd3;

   localparam logic [ADDR_W-1:0] TMR_PRESCALE = 8'd0;
   localparam logic [ADDR_W-1:0] TMR_RELOAD   = 8'd1;
   localparam logic [ADDR_W-1:0] TMR_COUNT    = 8'd2;

   localparam int unsigned CTRL_EN_BIT   = 0;
   localparam int unsigned CTRL_AR_BIT   = 1;
   localparam int unsigned CTRL_IRQ_BIT  = 2;
   localparam int unsigned STAT_EXP_BIT  = 0;
   localparam int unsigned STAT_EN_BIT   = 1;
   localparam int unsigned CTRL_W        = 3;

   // Bit order matches the CTRL word: irq_en=bit2, auto_reload=bit1, enable=bit0
   typedef struct packed {
      logic irq_en;
      logic auto_reload;
      logic enable;
   } timer_ctrl_t;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running divider: emits a one-cycle step each time the count reaches the limit.
module timer_prescaler
   import device_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              clear,
   input  logic [DATA_W-1:0] limit,
   output logic              step
);

   logic [DATA_W-1:0] r_pre;
   logic              w_hit;

   // >= so that lowering the limit below the running count fires at once
   assign w_hit = (r_pre >= limit);
   assign step  = enable & w_hit;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_pre <= '0;
      end else if (clear) begin
         r_pre <= '0;
      end else if (enable) begin
         if (w_hit) r_pre <= '0;
         else       r_pre <= r_pre + DATA_W'(1);
      end
   end

endmodule

// File: rtl/timer_device.sv
// Memory-mapped countdown timer for device slot 0x03: register file, countdown
// logic and combinational read mux around a shared prescaler.
module timer_device
   import device_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              write_enable,
   input  logic              control,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              irq,
   output logic              tick
);

   timer_ctrl_t       r_ctrl;
   logic              r_expired;
   logic              r_tick;
   logic [DATA_W-1:0] r_prescale;
   logic [DATA_W-1:0] r_reload;
   logic [DATA_W-1:0] r_count;

   logic              w_wr_ctrl;
   logic              w_wr_status;
   logic              w_wr_prescale;
   logic              w_wr_reload;
   logic              w_wr_count;
   timer_ctrl_t       w_ctrl_wdata;
   timer_ctrl_t       w_ctrl_next;
   logic              w_en_rise;
   logic              w_step;
   logic              w_expire;
   logic              w_w1c;

   assign w_wr_ctrl     = write_enable &  control & (address == CTL_CTRL);
   assign w_wr_status   = write_enable &  control & (address == CTL_STATUS);
   assign w_wr_prescale = write_enable & ~control & (address == TMR_PRESCALE);
   assign w_wr_reload   = write_enable & ~control & (address == TMR_RELOAD);
   assign w_wr_count    = write_enable & ~control & (address == TMR_COUNT);

   assign w_ctrl_wdata = timer_ctrl_t'(data_in[CTRL_W-1:0]);
   assign w_en_rise    = w_wr_ctrl & w_ctrl_wdata.enable & ~r_ctrl.enable;
   assign w_w1c        = w_wr_status & data_in[STAT_EXP_BIT];

   timer_prescaler u_prescaler (
      .clock   (clock),
      .reset_n (reset_n),
      .enable  (r_ctrl.enable),
      .clear   (w_en_rise),
      .limit   (r_prescale),
      .step    (w_step)
   );

   // A COUNT write in the step cycle wins and the step is dropped
   assign w_expire = w_step & ~w_wr_count & (r_count == '0);

   // One-shot expiry forces enable low even against a same-cycle CTRL write
   always_comb begin
      w_ctrl_next = r_ctrl;
      if (w_wr_ctrl) w_ctrl_next = w_ctrl_wdata;
      if (w_expire && !r_ctrl.auto_reload) w_ctrl_next.enable = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_ctrl     <= '0;
         r_expired  <= 1'b0;
         r_tick     <= 1'b0;
         r_prescale <= '0;
         r_reload   <= '0;
         r_count    <= '0;
      end else begin
         r_ctrl    <= w_ctrl_next;
         r_tick    <= w_expire;
         r_expired <= (r_expired & ~w_w1c) | w_expire;
         if (w_wr_prescale) r_prescale <= data_in;
         if (w_wr_reload)   r_reload   <= data_in;
         if (w_wr_count) begin
            r_count <= data_in;
         end else if (w_step) begin
            if (r_count != '0)           r_count <= r_count - DATA_W'(1);
            else if (r_ctrl.auto_reload) r_count <= r_reload;
         end
      end
   end

   always_comb begin
      data_out = '0;
      if (control) begin
         case (address)
            CTL_ID:     data_out = TIMER_DEVICE_ID;
            CTL_TYPE:   data_out = TIMER_DEVICE_TYPE;
            CTL_CTRL:   data_out = DATA_W'(r_ctrl);
            CTL_STATUS: data_out = DATA_W'({r_ctrl.enable, r_expired});
            default:    data_out = '0;
         endcase
      end else begin
         case (address)
            TMR_PRESCALE: data_out = r_prescale;
            TMR_RELOAD:   data_out = r_reload;
            TMR_COUNT:    data_out = r_count;
            default:      data_out = '0;
         endcase
      end
   end

   assign irq  = r_expired & r_ctrl.irq_en;
   assign tick = r_tick;

endmodule

// File: tb/tb_timer_device.sv
// Directed bench for timer_device: register reads and tick times checked
// against expectations queued when the stimulus is applied.
module tb_timer_device;

   logic        clock;
   logic        reset_n;
   logic        write_enable;
   logic        control;
   logic [7:0]  address;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        irq;
   logic        tick;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          w;
   int          tick_log[$];
   logic [31:0] rd_q[$];
   int          tick_exp_q[$];

   timer_device dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .write_enable (write_enable),
      .control      (control),
      .address      (address),
      .data_in      (data_in),
      .data_out     (data_out),
      .irq          (irq),
      .tick         (tick)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;
   always @(negedge clock) if (tick === 1'b1) tick_log.push_back(cyc);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Called at a negedge; the write lands on the following rising edge
   task automatic wr(input logic ctl, input logic [7:0] addr, input logic [15:0] d);
      control      = ctl;
      address      = addr;
      data_in      = d;
      write_enable = 1'b1;
      @(negedge clock);
      write_enable = 1'b0;
   endtask

   task automatic rd(input logic ctl, input logic [7:0] addr, input logic [15:0] want,
                     input string tag);
      logic [31:0] e;
      rd_q.push_back(32'(want));
      control = ctl;
      address = addr;
      #1;
      e = rd_q.pop_front();
      chk(tag, 32'(data_out), e);
   endtask

   task automatic chk_ticks(input int n, input string tag);
      int got;
      chk({tag, "_count"}, 32'(tick_log.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         got = (i < tick_log.size()) ? tick_log[i] : -1;
         chk({tag, "_cyc"}, 32'(got), 32'(tick_exp_q.pop_front()));
      end
      tick_exp_q.delete();
   endtask

   initial begin
      reset_n = 1'b0; write_enable = 1'b0; control = 1'b0;
      address = '0;   data_in = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      // reset state and identity
      rd(1'b1, 8'd0, 16'h0300, "id");
      rd(1'b1, 8'd1, 16'h0004, "type");
      rd(1'b1, 8'd2, 16'h0000, "rst_ctrl");
      rd(1'b1, 8'd3, 16'h0000, "rst_status");
      rd(1'b0, 8'd2, 16'h0000, "rst_count");
      rd(1'b1, 8'd9, 16'h0000, "unmapped_ctl");
      chk("rst_irq",  32'(irq),  32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      wr(1'b0, 8'd7, 16'hBEEF);
      rd(1'b0, 8'd7, 16'h0000, "unmapped_wr");

      // auto-reload: period (3+1)*(4+1) = 20
      wr(1'b0, 8'd0, 16'd3);
      wr(1'b0, 8'd1, 16'd4);
      wr(1'b0, 8'd2, 16'd4);
      tick_log.delete();
      wr(1'b1, 8'd2, 16'h0003);
      w = cyc;
      tick_exp_q.push_back(w + 20);
      tick_exp_q.push_back(w + 40);
      tick_exp_q.push_back(w + 60);
      repeat (21) @(negedge clock);
      rd(1'b1, 8'd3, 16'h0003, "ar_status");
      chk("ar_irq_off", 32'(irq), 32'd0);
      wr(1'b1, 8'd2, 16'h0007);
      chk("ar_irq_on", 32'(irq), 32'd1);
      wr(1'b1, 8'd3, 16'h0001);
      chk("ar_irq_w1c", 32'(irq), 32'd0);
      rd(1'b1, 8'd3, 16'h0002, "ar_status_w1c");
      repeat (w + 61 - cyc) @(negedge clock);
      rd(1'b0, 8'd2, 16'd4, "ar_reloaded");
      rd(1'b1, 8'd3, 16'h0003, "ar_status2");
      chk_ticks(3, "ar_tick");
      wr(1'b1, 8'd2, 16'h0000);
      wr(1'b1, 8'd3, 16'h0001);

      // one-shot
      wr(1'b0, 8'd0, 16'd0);
      wr(1'b0, 8'd2, 16'd2);
      tick_log.delete();
      wr(1'b1, 8'd2, 16'h0001);
      w = cyc;
      tick_exp_q.push_back(w + 3);
      repeat (55) @(negedge clock);
      chk_ticks(1, "os_tick");
      rd(1'b1, 8'd2, 16'h0000, "os_ctrl");
      rd(1'b0, 8'd2, 16'h0000, "os_count");
      rd(1'b1, 8'd3, 16'h0001, "os_status");

      // COUNT write on the step edge
      wr(1'b1, 8'd3, 16'h0001);
      wr(1'b0, 8'd0, 16'd3);
      wr(1'b0, 8'd2, 16'd5);
      wr(1'b1, 8'd2, 16'h0001);
      repeat (3) @(negedge clock);
      rd(1'b0, 8'd2, 16'd5, "col_prestep");
      wr(1'b0, 8'd2, 16'h0010);
      rd(1'b0, 8'd2, 16'h0010, "col_write_wins");
      repeat (3) @(negedge clock);
      rd(1'b0, 8'd2, 16'h0010, "col_hold");
      @(negedge clock);
      rd(1'b0, 8'd2, 16'h000F, "col_next_step");
      wr(1'b1, 8'd2, 16'h0000);

      // W1C on the expiring edge
      wr(1'b1, 8'd3, 16'h0001);
      wr(1'b0, 8'd0, 16'd1);
      wr(1'b0, 8'd2, 16'd0);
      tick_log.delete();
      wr(1'b1, 8'd2, 16'h0001);
      w = cyc;
      tick_exp_q.push_back(w + 2);
      @(negedge clock);
      wr(1'b1, 8'd3, 16'h0001);
      rd(1'b1, 8'd3, 16'h0001, "w1c_set_wins");
      @(negedge clock);
      chk_ticks(1, "w1c_tick");

      // PRESCALE lowered below the running count
      wr(1'b1, 8'd3, 16'h0001);
      wr(1'b0, 8'd0, 16'd100);
      wr(1'b0, 8'd2, 16'd5);
      wr(1'b1, 8'd2, 16'h0001);
      repeat (50) @(negedge clock);
      wr(1'b0, 8'd0, 16'd2);
      rd(1'b0, 8'd2, 16'd5, "ps_before");
      @(negedge clock);
      rd(1'b0, 8'd2, 16'd4, "ps_step_now");
      repeat (2) @(negedge clock);
      rd(1'b0, 8'd2, 16'd4, "ps_hold");
      @(negedge clock);
      rd(1'b0, 8'd2, 16'd3, "ps_next");
      wr(1'b1, 8'd2, 16'h0000);

      // reset while counting
      wr(1'b0, 8'd0, 16'd0);
      wr(1'b0, 8'd1, 16'd7);
      wr(1'b0, 8'd2, 16'd5);
      tick_log.delete();
      wr(1'b1, 8'd2, 16'h0007);
      repeat (2) @(negedge clock);
      rd(1'b0, 8'd2, 16'd3, "rm_running");
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (20) @(negedge clock);
      chk_ticks(0, "rm_tick");
      rd(1'b1, 8'd2, 16'h0000, "rm_ctrl");
      rd(1'b1, 8'd3, 16'h0000, "rm_status");
      rd(1'b0, 8'd0, 16'h0000, "rm_prescale");
      rd(1'b0, 8'd1, 16'h0000, "rm_reload");
      rd(1'b0, 8'd2, 16'h0000, "rm_count");
      rd(1'b1, 8'd0, 16'h0300, "rm_id");
      chk("rm_irq", 32'(irq), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
